// File: rtl/knightrider_scheduler_if.sv
// Handshake/status bundle for the knightrider_scheduler LED scanner.
// The master drives requests and motion controls; the slave returns the LED/status view.
interface knightrider_scheduler_if;
  logic       start;
  logic       stop;
  logic [1:0] mode;
  logic [3:0] speed;
  logic [7:0] leds;
  logic [2:0] pos;
  logic       dir;
  logic       busy;
  logic       step;
  logic       sweep_done;

  modport master (
    output start, stop, mode, speed,
    input  leds, pos, dir, busy, step, sweep_done
  );

  modport slave (
    input  start, stop, mode, speed,
    output leds, pos, dir, busy, step, sweep_done
  );
endinterface

// File: rtl/knightrider_scheduler.sv
// Scanning-LED position scheduler: bounce / wrap-up / wrap-down / hold motion, drain to HOME on stop.
// Define KNIGHTRIDER_TRAIL_EN to also light the previously visited position while busy.
module knightrider_scheduler #(
  parameter int unsigned TICK_DIV = 4,
  parameter logic [2:0]  HOME     = 3'd0
) (
  input  logic                  clk,
  input  logic                  arst_n,
  knightrider_scheduler_if.slave bus
);
  localparam int CNT_W = 21;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       spd;
  logic [2:0]       pos_r;
  logic             dir_r;
  logic [7:0]       leds_r;
  logic             busy_r;
  logic             step_r;
  logic             done_r;

  logic [CNT_W-1:0] period_m1;
  logic             terminal;
  logic             adv;
  logic [2:0]       run_pos;
  logic             run_dir;
  logic             run_done;
  logic [2:0]       drain_pos;
  logic             drain_dir;

  function automatic logic [7:0] onehot(input logic [2:0] p);
    return 8'b1 << p;
  endfunction

  // Returns {dir, pos} after one step in the given motion mode.
  function automatic logic [3:0] run_move(input logic [1:0] m, input logic [2:0] p, input logic d);
    logic [3:0] res;
    res = {d, p};
    case (m)
      2'b00: begin
        if (d && p == 3'd7)       res = {1'b0, 3'd6};
        else if (!d && p == 3'd0) res = {1'b1, 3'd1};
        else if (d)               res = {1'b1, p + 3'd1};
        else                      res = {1'b0, p - 3'd1};
      end
      2'b01:   res = {1'b1, p + 3'd1};
      2'b10:   res = {1'b0, p - 3'd1};
      default: res = {d, p};
    endcase
    return res;
  endfunction

  function automatic logic sweep_hit(input logic [1:0] m, input logic [2:0] p);
    logic hit;
    case (m)
      2'b00:   hit = (p == 3'd0) || (p == 3'd7);
      2'b01:   hit = (p == 3'd0);
      2'b10:   hit = (p == 3'd7);
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  assign period_m1 = (CNT_W'(spd) + CNT_W'(1)) * CNT_W'(TICK_DIV) - CNT_W'(1);
  assign terminal  = (cnt == period_m1);

  // A step only fires when no request redirects the FSM on the same edge.
  always_comb begin
    adv = 1'b0;
    if (terminal) begin
      if (state == RUN)   adv = !bus.stop;
      if (state == DRAIN) adv = !bus.start;
    end
    {run_dir, run_pos} = run_move(bus.mode, pos_r, dir_r);
    run_done = sweep_hit(bus.mode, run_pos);
    if (pos_r > HOME) begin
      drain_pos = pos_r - 3'd1;
      drain_dir = 1'b0;
    end else begin
      drain_pos = pos_r + 3'd1;
      drain_dir = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state  <= IDLE;
      pos_r  <= HOME;
      dir_r  <= 1'b1;
      leds_r <= 8'h00;
      busy_r <= 1'b0;
      step_r <= 1'b0;
      done_r <= 1'b0;
      cnt    <= '0;
      spd    <= '0;
    end else begin
      step_r <= adv;
      done_r <= 1'b0;
      if (adv) begin
        cnt <= '0;
        spd <= bus.speed;
      end
      case (state)
        IDLE: begin
          cnt <= '0;
          spd <= bus.speed;
          if (bus.start) begin
            state  <= RUN;
            busy_r <= 1'b1;
            leds_r <= onehot(pos_r);
          end
        end
        RUN: begin
          if (bus.stop) begin
            cnt <= '0;
            if (pos_r == HOME) begin
              state  <= IDLE;
              busy_r <= 1'b0;
              leds_r <= 8'h00;
            end else begin
              state <= DRAIN;
            end
          end else if (adv) begin
            pos_r  <= run_pos;
            dir_r  <= run_dir;
            done_r <= run_done;
            leds_r <= onehot(run_pos);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (bus.start) begin
            state <= RUN;
            cnt   <= '0;
          end else if (adv) begin
            pos_r <= drain_pos;
            dir_r <= drain_dir;
            if (drain_pos == HOME) begin
              state  <= IDLE;
              busy_r <= 1'b0;
              leds_r <= 8'h00;
            end else begin
              leds_r <= onehot(drain_pos);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef KNIGHTRIDER_TRAIL_EN
  logic [2:0] prev_pos;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)                              prev_pos <= HOME;
    else if ((state == IDLE && bus.start) || adv) prev_pos <= pos_r;
  end

  assign bus.leds = leds_r | (busy_r ? onehot(prev_pos) : 8'h00);
`else
  assign bus.leds = leds_r;
`endif

  assign bus.pos        = pos_r;
  assign bus.dir        = dir_r;
  assign bus.busy       = busy_r;
  assign bus.step       = step_r;
  assign bus.sweep_done = done_r;
endmodule

// File: doc/knightrider_scheduler.md
KNIGHTRIDER_SCHEDULER -- requirements
Module: knightrider_scheduler

Interface
REQ-001 Parameter TICK_DIV, default 4, meaning clock cycles per base tick (legal range 1..65535).
REQ-002 Parameter HOME, default 3'd0, meaning the park position reached before returning to idle.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 arst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  level-sampled request to begin or resume animation.
REQ-006 stop  input  1  level-sampled request to drain to HOME and go idle.
REQ-007 mode  input  2  motion mode: 00 bounce, 01 wrap-up, 10 wrap-down, 11 hold.
REQ-008 speed  input  4  step period = (speed+1)*TICK_DIV cycles.
REQ-009 leds  output  8  LED drive pattern.
REQ-010 pos  output  3  current lit position.
REQ-011 dir  output  1  1 = up (toward 7), 0 = down.
REQ-012 busy  output  1  high in RUN or DRAIN.
REQ-013 step  output  1  one-cycle pulse on the cycle pos is updated.
REQ-014 sweep_done  output  1  one-cycle pulse coincident with step when an endpoint is reached.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DRAIN.
REQ-016 IDLE: start=1 -> RUN next cycle; stop ignored; divider cleared; speed latched.
REQ-017 RUN: stop=1 -> DRAIN, or -> IDLE directly if pos==HOME; stop wins over simultaneous start.
REQ-018 DRAIN: start=1 -> RUN (pos, dir retained); otherwise step toward HOME; -> IDLE on the step that makes pos==HOME.
REQ-019 The divider SHALL count one step period; on terminal count it SHALL assert step, update pos, reload, and re-latch speed (speed changes take effect only at a step boundary).
REQ-020 First step after entering RUN from IDLE SHALL occur exactly one full period later.
REQ-021 Bounce: no dwell at ends; dir=1 and pos==7 -> pos 6, dir 0; dir=0 and pos==0 -> pos 1, dir 1; otherwise pos +/-1 per dir.
REQ-022 Wrap-up: pos = (pos+1) mod 8, dir=1; wrap-down: pos = (pos-1) mod 8, dir=0.
REQ-023 Hold: pos unchanged, step still pulses, sweep_done never pulses.
REQ-024 sweep_done: bounce when new pos is 0 or 7; wrap-up when new pos is 0; wrap-down when new pos is 7; never in DRAIN.
REQ-025 DRAIN motion SHALL ignore mode: dir forced to 0 if pos>HOME, else 1, pos moves one step toward HOME per period.
REQ-026 Mode changes SHALL take effect at the next step; no pos change between steps.
REQ-027 leds SHALL be 8'h00 in IDLE and one-hot of pos (bit pos) in RUN/DRAIN, registered, updated the same cycle as pos.
REQ-028 busy SHALL be registered and high exactly while state is RUN or DRAIN.

Reset
REQ-029 arst_n low SHALL immediately force IDLE, pos=HOME, dir=1, leds=8'h00, busy=0, step=0, sweep_done=0, divider=0, latched speed=0, independent of clk.
REQ-030 Reset asserted mid-RUN or mid-DRAIN SHALL abandon the sweep with no further step pulses; after release, the block waits in IDLE for start.

Configuration
REQ-031 Macro KNIGHTRIDER_TRAIL_EN defined: block holds prev_pos, updated to old pos on each step; leds in RUN/DRAIN = onehot(pos) | onehot(prev_pos); prev_pos = pos on entry to RUN from IDLE and on reset (single LED until first step).
REQ-032 Macro KNIGHTRIDER_TRAIL_EN undefined: no prev_pos register; leds strictly one-hot per REQ-027; all other behaviour identical.

Verification (TICK_DIV=2, HOME=0, trail disabled unless stated)
REQ-033 Bounce, speed=0, start pulse -> pos 0,1,...,7,6,...,0,1 every 2 cycles; leds 01,02,...,80,40; sweep_done at pos 7 and 0 only.
REQ-034 Wrap-up from pos 6 -> pos 7 then 0 with sweep_done on 0; wrap-down from 1 -> 0 then 7 with sweep_done on 7.
REQ-035 Bounce, stop at pos 5 dir up -> DRAIN pos 4,3,2,1,0, then IDLE, busy=0, leds=00; no sweep_done during drain.
REQ-036 start+stop same cycle: in IDLE -> RUN; in RUN at pos 3 -> DRAIN; start during DRAIN at pos 2 -> RUN resumes from pos 2.
REQ-037 speed=3 -> step every 8 cycles; speed changed to 0 mid-period -> current period completes at 8, subsequent periods 2.
REQ-038 arst_n pulsed low mid-RUN at pos 6 -> outputs zero/HOME asynchronously; with KNIGHTRIDER_TRAIL_EN, bounce step 2->3 shows leds=8'h0C.
